// File: rtl/plic_lite_if.sv
// plic_lite_if: configuration, claim and completion bus between the trap path and the PLIC
interface plic_lite_if #(
  parameter int ID_W = 4
);
  logic            cfg_we;
  logic [ID_W-1:0] cfg_addr;
  logic [31:0]     cfg_wdata;
  logic            claim_req;
  logic            complete_valid;
  logic [ID_W-1:0] complete_id;
  logic            claim_ack;
  logic [ID_W-1:0] claim_id;
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, claim_req, complete_valid, complete_id,
    input  claim_ack, claim_id
  );
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, claim_req, complete_valid, complete_id,
    output claim_ack, claim_id
  );
endinterface

// File: rtl/plic_lite.sv
// plic_lite: per-source gateways, priority/threshold arbitration and claim/complete handshake
module plic_lite #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3,
  parameter int ID_W   = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [NSRC-1:0] src,
  plic_lite_if.slave      bus,
  output logic            ext_irq,
  output logic [NSRC-1:0] inservice
);
  logic [NSRC-1:0]   pend, en, elig, grant, done;
  logic [PRIO_W-1:0] prio [NSRC];
  logic [PRIO_W-1:0] thr, win_prio;
  logic [ID_W-1:0]   win_id;
  logic [31:0]       addr;
  logic              unused_wdata;
  assign addr = 32'(bus.cfg_addr);
  assign unused_wdata = ^bus.cfg_wdata;
  // eligibility and winner: strict compare keeps the lowest ID on equal priority
  always_comb begin
    elig = '0;
    win_id = '0;
    win_prio = '0;
    for (int i = 0; i < NSRC; i++) begin
      elig[i] = pend[i] & en[i] & (prio[i] > thr);
      if (elig[i] && prio[i] > win_prio) begin
        win_id = ID_W'(i + 1);
        win_prio = prio[i];
      end
    end
  end
  // one-hot claim grant and valid completion per source; bogus IDs match nothing
  always_comb begin
    grant = '0;
    done = '0;
    for (int i = 0; i < NSRC; i++) begin
      grant[i] = bus.claim_req && win_id == ID_W'(i + 1);
      done[i] = bus.complete_valid && bus.complete_id == ID_W'(i + 1) && inservice[i];
    end
  end
  // gateways: IDLE->PEND on src, PEND->INSV on grant, INSV->IDLE on completion
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      pend <= '0;
      inservice <= '0;
    end else begin
      pend <= (pend & ~grant) | (src & ~pend & ~inservice);
      inservice <= (inservice & ~done) | grant;
    end
  // configuration registers: threshold, priorities, enable mask
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      thr <= '0;
      en <= '0;
      for (int i = 0; i < NSRC; i++) prio[i] <= '0;
    end else if (bus.cfg_we) begin
      if (addr == 0) thr <= bus.cfg_wdata[PRIO_W-1:0];
      if (addr == 32'(NSRC + 1)) en <= bus.cfg_wdata[NSRC-1:0];
      for (int i = 0; i < NSRC; i++)
        if (addr == 32'(i + 1)) prio[i] <= bus.cfg_wdata[PRIO_W-1:0];
    end
  // registered outputs: interrupt line and claim response
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ext_irq <= 1'b0;
      bus.claim_ack <= 1'b0;
      bus.claim_id <= '0;
    end else begin
      ext_irq <= |elig;
      bus.claim_ack <= bus.claim_req;
      bus.claim_id <= bus.claim_req ? win_id : '0;
    end
endmodule

// File: tb/tb_plic_lite.sv
// tb_plic_lite: directed and random stimulus checked against a behavioural PLIC model
module tb_plic_lite;
  localparam int NSRC = 8;
  localparam int PRIO_W = 3;
  localparam int ID_W = 4;
  logic clk, resetn;
  logic [NSRC-1:0] src, inservice;
  logic ext_irq;
  int n_chk, n_fail;
  plic_lite_if #(.ID_W(ID_W)) bus ();
  plic_lite #(.NSRC(NSRC), .PRIO_W(PRIO_W), .ID_W(ID_W)) dut (
    .clk(clk), .resetn(resetn), .src(src), .bus(bus), .ext_irq(ext_irq), .inservice(inservice)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  // behavioural model: sources indexed by ID 1..NSRC
  bit m_pnd [NSRC+1];
  bit m_ins [NSRC+1];
  int m_pr [NSRC+1];
  int m_thr;
  bit [NSRC-1:0] m_en;
  logic [31:0] e_irq, e_ack, e_id;
  task automatic m_reset();
    for (int id = 0; id <= NSRC; id++) begin
      m_pnd[id] = 0;
      m_ins[id] = 0;
      m_pr[id] = 0;
    end
    m_thr = 0;
    m_en = '0;
    e_irq = 0;
    e_ack = 0;
    e_id = 0;
  endtask
  function automatic int m_winner();
    for (int p = (1 << PRIO_W) - 1; p > m_thr; p--)
      for (int id = 1; id <= NSRC; id++)
        if (m_pnd[id] && m_en[id-1] && m_pr[id] == p) return id;
    return 0;
  endfunction
  function automatic logic [31:0] m_insv();
    logic [31:0] v = 0;
    for (int id = 1; id <= NSRC; id++) v[id-1] = m_ins[id];
    return v;
  endfunction
  task automatic model_edge();
    int w;
    int a;
    bit np [NSRC+1];
    bit ni [NSRC+1];
    w = m_winner();
    e_irq = (w != 0) ? 1 : 0;
    e_ack = bus.claim_req ? 1 : 0;
    e_id = bus.claim_req ? w : 0;
    for (int id = 1; id <= NSRC; id++) begin
      np[id] = m_pnd[id];
      ni[id] = m_ins[id];
      if (m_ins[id]) begin
        if (bus.complete_valid && bus.complete_id == id) ni[id] = 0;
      end else if (m_pnd[id]) begin
        if (bus.claim_req && w == id) begin
          np[id] = 0;
          ni[id] = 1;
        end
      end else if (src[id-1]) np[id] = 1;
    end
    for (int id = 1; id <= NSRC; id++) begin
      m_pnd[id] = np[id];
      m_ins[id] = ni[id];
    end
    if (bus.cfg_we) begin
      a = int'(bus.cfg_addr);
      if (a == 0) m_thr = int'(bus.cfg_wdata % (1 << PRIO_W));
      else if (a <= NSRC) m_pr[a] = int'(bus.cfg_wdata % (1 << PRIO_W));
      else if (a == NSRC + 1) m_en = bus.cfg_wdata[NSRC-1:0];
    end
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all();
    chk("ext_irq", 32'(ext_irq), e_irq);
    chk("claim_ack", 32'(bus.claim_ack), e_ack);
    chk("claim_id", 32'(bus.claim_id), e_id);
    chk("inservice", 32'(inservice), m_insv());
  endtask
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk_all();
    bus.cfg_we = 0;
    bus.claim_req = 0;
    bus.complete_valid = 0;
  endtask
  task automatic wr(int a, int d);
    bus.cfg_we = 1;
    bus.cfg_addr = ID_W'(a);
    bus.cfg_wdata = 32'(d);
    cycle();
  endtask
  task automatic claim();
    bus.claim_req = 1;
    cycle();
  endtask
  task automatic comp(int id);
    bus.complete_valid = 1;
    bus.complete_id = ID_W'(id);
    cycle();
  endtask
  task automatic pulse(logic [NSRC-1:0] s);
    src = s;
    cycle();
    src = '0;
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    resetn = 0;
    src = '0;
    bus.cfg_we = 0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    bus.claim_req = 0;
    bus.complete_valid = 0;
    bus.complete_id = '0;
    m_reset();
    #2;
    chk_all();
    #10 resetn = 1;
    // single source
    wr(NSRC + 1, 8'h01);
    wr(1, 3);
    wr(0, 0);
    src = 8'h01;
    cycle();
    chk("irq_before_latency", 32'(ext_irq), 0);
    src = '0;
    cycle();
    chk("irq_after_edge1", 32'(ext_irq), 1);
    claim();
    chk("single_claim_id", 32'(bus.claim_id), 1);
    chk("single_insv", 32'(inservice), 32'h01);
    comp(1);
    chk("single_complete", 32'(inservice), 32'h00);
    // priority and tie-break, one-cycle pulses, back-to-back claims
    wr(2, 5);
    wr(5, 5);
    wr(3, 7);
    wr(NSRC + 1, 8'hFF);
    pulse(8'b0001_0110);
    cycle();
    claim();
    chk("tie_claim_a", 32'(bus.claim_id), 3);
    claim();
    chk("tie_claim_b", 32'(bus.claim_id), 2);
    claim();
    chk("tie_claim_c", 32'(bus.claim_id), 5);
    claim();
    chk("tie_claim_d", 32'(bus.claim_id), 0);
    chk("tie_ack_d", 32'(bus.claim_ack), 1);
    comp(3);
    comp(2);
    comp(5);
    // threshold
    wr(4, 2);
    wr(0, 2);
    pulse(8'b0000_1000);
    cycle();
    cycle();
    chk("thr_irq_low", 32'(ext_irq), 0);
    claim();
    chk("thr_claim_none", 32'(bus.claim_id), 0);
    wr(0, 1);
    cycle();
    chk("thr_irq_high", 32'(ext_irq), 1);
    claim();
    chk("thr_claim_4", 32'(bus.claim_id), 4);
    comp(4);
    // re-arm with src held high
    src = 8'h01;
    cycle();
    cycle();
    claim();
    chk("rearm_claim1", 32'(bus.claim_id), 1);
    cycle();
    cycle();
    chk("rearm_no_pend", 32'(ext_irq), 0);
    comp(1);
    cycle();
    claim();
    chk("rearm_claim2", 32'(bus.claim_id), 1);
    src = '0;
    comp(1);
    // bogus completions, then claim and complete together
    pulse(8'b0000_0010);
    claim();
    chk("bogus_setup", 32'(bus.claim_id), 2);
    comp(0);
    comp(9);
    comp(3);
    chk("bogus_insv", 32'(inservice), 32'h02);
    pulse(8'b0001_0000);
    bus.complete_valid = 1;
    bus.complete_id = ID_W'(2);
    claim();
    chk("same_cycle_id", 32'(bus.claim_id), 5);
    chk("same_cycle_insv", 32'(inservice), 32'h10);
    comp(5);
    wr(12, 8'h00);
    chk("ignored_write", 32'(m_en), 32'hFF);
    // asynchronous reset with source 3 in service
    pulse(8'b0000_0100);
    claim();
    chk("rst_setup", 32'(inservice), 32'h04);
    #2 resetn = 0;
    #1;
    m_reset();
    chk_all();
    #1 resetn = 1;
    src = 8'hFF;
    cycle();
    cycle();
    cycle();
    chk("post_rst_irq", 32'(ext_irq), 0);
    claim();
    chk("post_rst_claim", 32'(bus.claim_id), 0);
    src = '0;
    // random traffic against the model
    for (int id = 1; id <= NSRC; id++) wr(id, $urandom_range(0, 7));
    wr(NSRC + 1, 8'hFF);
    wr(0, 1);
    for (int k = 0; k < 400; k++) begin
      src = NSRC'($urandom & $urandom);
      bus.claim_req = ($urandom % 3) == 0;
      bus.complete_valid = $urandom % 2;
      bus.complete_id = ($urandom % 4 == 0) ? ID_W'($urandom_range(0, 15)) : ID_W'($urandom_range(1, NSRC));
      bus.cfg_we = ($urandom % 8) == 0;
      bus.cfg_addr = ID_W'($urandom_range(0, 15));
      bus.cfg_wdata = $urandom;
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/plic_lite.md
PLIC_LITE -- requirements
Module: plic_lite

Interface
REQ-001 Parameter NSRC, default 8: number of external interrupt sources, with IDs 1..NSRC; ID 0 means "no interrupt".
REQ-002 Parameter PRIO_W, default 3: width of each source priority and of the threshold.
REQ-003 Parameter ID_W, default 4: width of claim/complete IDs; NSRC < 2^ID_W is required.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 resetn  in  1: reset, asynchronous, active-low.
REQ-006 src  in  NSRC: level-sensitive interrupt requests; bit i-1 is source ID i.
REQ-007 cfg_we  in  1: configuration write strobe.
REQ-008 cfg_addr  in  ID_W: configuration address. 0 = threshold; 1..NSRC = priority of that source; NSRC+1 = enable mask.
REQ-009 cfg_wdata  in  32: write data; LSBs are used (PRIO_W bits or NSRC bits).
REQ-010 claim_req  in  1: single-cycle claim request from the trap path.
REQ-011 complete_valid  in  1: completion strobe.
REQ-012 complete_id  in  ID_W: ID being completed.
REQ-013 ext_irq  out  1: external interrupt pending; drives mip[11].
REQ-014 claim_ack  out  1: claim response valid, one cycle wide.
REQ-015 claim_id  out  ID_W: claimed ID, valid while claim_ack is high.
REQ-016 inservice  out  NSRC: per-source in-service status.

Function
REQ-017 Each source has a gateway with three states.
- IDLE -> PEND at the clock edge where src=1.
- PEND -> INSV on the edge that claims it.
- INSV -> IDLE on the edge with complete_valid=1 and complete_id equal to that source.
REQ-018 While a source is in INSV, its src input is ignored. If src is still 1 after completion, the source re-enters PEND one cycle after returning to IDLE.
REQ-019 Once pending, a source stays PEND even if src drops (pending is latched).
REQ-020 A source is eligible when it is PEND, its enable bit is 1, and its priority > threshold. A source with priority 0 is never eligible.
REQ-021 The winner is the eligible source with the highest priority; ties go to the lowest ID.
REQ-022 ext_irq is registered: ext_irq <= (an eligible source exists).
- Latency from src rising to ext_irq high: 2 cycles.
- ext_irq may stay high for 1 stale cycle after a claim.
REQ-023 A claim_req sampled at edge k does the following at that same edge:
- registers claim_ack=1 and claim_id=winner;
- moves the winner to INSV.
claim_ack is high for exactly the cycle after edge k.
REQ-024 A claim with no eligible source returns claim_ack=1 and claim_id=0, with no state change.
REQ-025 A completion whose ID is 0, greater than NSRC, or not in INSV is ignored with no side effect.
REQ-026 Claim and complete in the same cycle are both applied.
- The completed source is not claimable in that cycle.
- Claim arbitration uses the state and configuration from before the edge.
REQ-027 A configuration write takes effect at the edge after cfg_we. A claim in the same cycle uses the pre-write values.
REQ-028 Writes to an address greater than NSRC+1 are ignored.
REQ-029 Lowering a source's priority or enable bit never cancels PEND or INSV; it only affects eligibility.
REQ-030 A src pulse lasting one cycle is captured.
REQ-031 claim_req held high for multiple cycles produces one claim per cycle.

Reset
REQ-032 When resetn=0, asynchronously:
- all gateways go to IDLE;
- all priorities, the threshold and the enable mask go to 0;
- ext_irq=0, claim_ack=0, claim_id=0, inservice=0.
REQ-033 Reset asserted mid-claim or while sources are in service discards all in-flight state. After release, no interrupt is raised until the configuration is rewritten.
REQ-034 After resetn deasserts, the first state update occurs on the next rising edge.

Verification
REQ-035 Single source: enable=0x01, prio[1]=3, thr=0; src[0] rises at edge 0. Required: ext_irq=1 after edge 1; claim -> claim_id=1, inservice=0x01; complete_id=1 -> inservice=0x00.
REQ-036 Priority and tie-break: prio[2]=5, prio[5]=5, prio[3]=7, all enabled and pending. Claims return 3, then 2, then 5, then 0.
REQ-037 Threshold: prio[4]=2, thr=2, source 4 pending. ext_irq stays 0 and a claim returns 0. After writing thr=1, ext_irq=1 after 1 cycle.
REQ-038 Re-arm: src[0] held at 1 through claim and complete. No second PEND while in INSV; source 1 is PEND again 1 cycle after complete, and the next claim returns 1.
REQ-039 Bogus completes: complete_id=0, complete_id=9, and complete of a non-in-service source cause no change. A claim and a valid complete in the same cycle are both honored.
REQ-040 Async reset: resetn pulled low between edges with source 3 in INSV. Outputs read 0 immediately, without waiting for a clock edge.
